// File: rtl/calc1_pkg.sv
// Shared opcode/response encodings, sizing constants and the per-port FSM state type.
// Buses are big-endian ([0:N-1], bit 0 = MSB); values read as ordinary unsigned numbers.
package calc1_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 32;
  localparam int LATENCY   = 2;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/calc1_port.sv
// One requester port: two-cycle command capture, ALU evaluation and a one-cycle registered response.
// Shifts exist only when CALC1_SHIFT_EN is defined; otherwise opcodes 5/6 fall through as invalid.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [0:3]        cmd,
  input  logic [0:DATA_W-1] data,
  output logic [0:1]        resp,
  output logic [0:DATA_W-1] result
);

  state_t            state;
  logic [0:3]        op;
  logic [0:DATA_W-1] opa;
  logic [0:DATA_W-1] opb;
  logic [0:1]        code_q;
  logic [0:DATA_W-1] val_q;

  logic [0:1]        alu_code;
  logic [0:DATA_W-1] alu_val;
  logic [0:DATA_W]   sum;

  // sum[0] is the carry-out because bit 0 is the MSB.
  always_comb begin
    sum      = {1'b0, opa} + {1'b0, opb};
    alu_code = RESP_ERR;
    alu_val  = '0;
    case (op)
      CMD_ADD: begin
        if (!sum[0]) begin
          alu_code = RESP_OK;
          alu_val  = sum[1:DATA_W];
        end
      end
      CMD_SUB: begin
        if (opb <= opa) begin
          alu_code = RESP_OK;
          alu_val  = opa - opb;
        end
      end
`ifdef CALC1_SHIFT_EN
      CMD_SHL: begin
        alu_code = RESP_OK;
        alu_val  = opa << opb[27:31];
      end
      CMD_SHR: begin
        alu_code = RESP_OK;
        alu_val  = opa >> opb[27:31];
      end
`endif
      default: begin
        alu_code = RESP_ERR;
        alu_val  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      op     <= CMD_NOP;
      opa    <= '0;
      opb    <= '0;
      code_q <= RESP_NONE;
      val_q  <= '0;
      resp   <= RESP_NONE;
      result <= '0;
    end else begin
      resp   <= RESP_NONE;
      result <= '0;
      case (state)
        IDLE: begin
          if (cmd != CMD_NOP) begin
            op    <= cmd;
            opa   <= data;
            state <= OP2;
          end
        end
        OP2: begin
          opb   <= data;
          state <= EXEC;
        end
        EXEC: begin
          code_q <= alu_code;
          val_q  <= alu_val;
          state  <= RESP;
        end
        RESP: begin
          // Port is IDLE again during the response cycle, so a new command can be taken then.
          resp   <= code_q;
          result <= val_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc1_engine.sv
// Four independent calc1 ports sharing only clock and reset.
// Build with CALC1_SHIFT_EN defined to enable the shift opcodes.
module calc1_engine
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp4
);

  calc1_port u_port1 (
    .clk(c_clk), .reset(reset), .cmd(req1_cmd_in), .data(req1_data_in),
    .resp(out_resp1), .result(out_data1)
  );

  calc1_port u_port2 (
    .clk(c_clk), .reset(reset), .cmd(req2_cmd_in), .data(req2_data_in),
    .resp(out_resp2), .result(out_data2)
  );

  calc1_port u_port3 (
    .clk(c_clk), .reset(reset), .cmd(req3_cmd_in), .data(req3_data_in),
    .resp(out_resp3), .result(out_data3)
  );

  calc1_port u_port4 (
    .clk(c_clk), .reset(reset), .cmd(req4_cmd_in), .data(req4_data_in),
    .resp(out_resp4), .result(out_data4)
  );

endmodule

// File: tb/tb_calc1_engine.sv
// Scoreboard bench for calc1_engine: expected responses are queued per port when a command is
// driven and compared on the falling edge of the cycle they are due; all other cycles expect 0/0.
module tb_calc1_engine;

  typedef struct {
    int         due;
    logic [0:1] resp;
    logic [0:31] data;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [0:3]  cmd [4];
  logic [0:31] din [4];
  logic [0:1]  resp [4];
  logic [0:31] dout [4];

  exp_t sb [4][$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  calc1_engine dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req1_data_in(din[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(din[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(din[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(din[3]),
    .out_data1(dout[0]), .out_resp1(resp[0]),
    .out_data2(dout[1]), .out_resp2(resp[1]),
    .out_data3(dout[2]), .out_resp3(resp[2]),
    .out_data4(dout[3]), .out_resp4(resp[3])
  );

  // Reference behaviour of one command.
  function automatic void model(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                                output logic [0:1] r, output logic [0:31] d);
    longint s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = longint'(a) + longint'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
`ifdef CALC1_SHIFT_EN
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
`endif
      default: ;
    endcase
  endfunction

  task automatic pushExp(input int p, input logic [0:3] c, input logic [0:31] a,
                         input logic [0:31] b, input int due);
    logic [0:1]  r;
    logic [0:31] d;
    if (c != 4'd0) begin
      model(c, a, b, r, d);
      sb[p].push_back('{due: due, resp: r, data: d});
    end
  endtask

  task automatic check(input string tag, input logic [0:31] got, input logic [0:31] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, want);
    end
  endtask

  task automatic checkOutput();
    for (int p = 0; p < 4; p++) begin
      if (sb[p].size() > 0 && sb[p][0].due == cyc) begin
        check($sformatf("p%0d_resp", p + 1), 32'(resp[p]), 32'(sb[p][0].resp));
        check($sformatf("p%0d_data", p + 1), dout[p], sb[p][0].data);
        void'(sb[p].pop_front());
      end else begin
        check($sformatf("p%0d_idle_resp", p + 1), 32'(resp[p]), 32'd0);
        check($sformatf("p%0d_idle_data", p + 1), dout[p], 32'd0);
      end
    end
  endtask

  always @(negedge c_clk) if (mon_en) checkOutput();

  // Full command on one port; returns when the port can accept the next command.
  task automatic applyStimulus(input int p, input logic [0:3] c, input logic [0:31] a,
                               input logic [0:31] b);
    cmd[p] = c;
    din[p] = a;
    pushExp(p, c, a, b, cyc + 4);
    @(negedge c_clk);
    cmd[p] = 4'd0;
    din[p] = b;
    @(negedge c_clk);
    din[p] = $urandom;
    repeat (2) @(negedge c_clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'($urandom_range(0, 15));
      din[p] = $urandom;
    end
    repeat (4) begin
      @(negedge c_clk);
      mon_en = 1'b1;
      for (int p = 0; p < 4; p++) begin
        cmd[p] = 4'($urandom_range(0, 15));
        din[p] = $urandom;
      end
    end
    @(negedge c_clk);
    reset = 1'b1;
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;

    applyStimulus(0, 4'd1, 32'h1, 32'h01FF_FFFF);
    applyStimulus(0, 4'd1, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    applyStimulus(0, 4'd1, 32'h0, 32'h0);
    applyStimulus(0, 4'd2, 32'h1, 32'hF);
    applyStimulus(0, 4'd2, 32'hF, 32'hF);
    applyStimulus(0, 4'd3, 32'h1234, 32'h5);
    applyStimulus(0, 4'd4, 32'h1234, 32'h5);
    applyStimulus(0, 4'd0, 32'h1234, 32'h5);
    applyStimulus(0, 4'd5, 32'h1, 32'h2000_0004);
    applyStimulus(0, 4'd6, 32'h8000_0000, 32'd31);
    applyStimulus(0, 4'd5, 32'hA5A5_0001, 32'd0);
    applyStimulus(0, 4'd15, 32'h7, 32'h7);

    // All four ports launched on the same edge.
    cmd[0] = 4'd1; din[0] = 32'd5;   pushExp(0, 4'd1, 32'd5, 32'd7, cyc + 4);
    cmd[1] = 4'd2; din[1] = 32'd100; pushExp(1, 4'd2, 32'd100, 32'd1, cyc + 4);
    cmd[2] = 4'd5; din[2] = 32'd3;   pushExp(2, 4'd5, 32'd3, 32'd2, cyc + 4);
    cmd[3] = 4'd9; din[3] = 32'd11;  pushExp(3, 4'd9, 32'd11, 32'd12, cyc + 4);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    din[0] = 32'd7; din[1] = 32'd1; din[2] = 32'd2; din[3] = 32'd12;
    repeat (3) @(negedge c_clk);

    // Port2: commands during OP2/EXEC/RESP are dropped, the one in the response cycle is taken.
    cmd[1] = 4'd1; din[1] = 32'd10; pushExp(1, 4'd1, 32'd10, 32'd20, cyc + 4);
    @(negedge c_clk);
    cmd[1] = 4'd2; din[1] = 32'd20;
    @(negedge c_clk);
    cmd[1] = 4'd1; din[1] = 32'd999;
    @(negedge c_clk);
    cmd[1] = 4'd3; din[1] = 32'd888;
    @(negedge c_clk);
    cmd[1] = 4'd2; din[1] = 32'd50; pushExp(1, 4'd2, 32'd50, 32'd8, cyc + 4);
    @(negedge c_clk);
    cmd[1] = 4'd0; din[1] = 32'd8;
    repeat (3) @(negedge c_clk);

    // Reset pulse while port1 is in EXEC discards the command.
    cmd[0] = 4'd1; din[0] = 32'd1;
    @(negedge c_clk);
    cmd[0] = 4'd0; din[0] = 32'd2;
    @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);
    reset = 1'b1;
    repeat (3) @(negedge c_clk);
    applyStimulus(0, 4'd1, 32'd40, 32'd2);

    repeat (4) @(negedge c_clk);
    mon_en = 1'b0;
    for (int p = 0; p < 4; p++) check($sformatf("p%0d_sb_empty", p + 1), sb[p].size(), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
